// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package key_scan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  typedef logic [3:0] key_code_t;

  // True when exactly one row line is pulled low; all-high or ghosted
  // multi-low patterns are treated as no key.
  function automatic logic one_low(input logic [NUM_ROWS-1:0] r);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!r[i]) n = n + 3'd1;
    end
    return (n == 3'd1);
  endfunction

  // Index of the (lowest) low bit; only meaningful when one_low() holds.
  function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Free-running divider producing a one-clk strobe every DIV cycles.
// Shared with the 7-segment display driver.
module scan_tick #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);

  logic [W-1:0] div_q, div_d;

  assign tick = (div_q == DIV_LAST);

  // Count 0..DIV-1 and wrap on the strobe cycle.
  always_comb begin
    div_d = tick ? '0 : div_q + W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: walks the columns, debounces press and release of a
// single key and reports {row_idx, col_idx} with valid/down/release flags.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | walking columns, waiting for a clean one-low row pattern
// PRESS_DB | column frozen, counting stable ticks of the latched pattern
// HELD     | key accepted, watching only the latched row for release
// REL_DB   | latched row high, counting stable released ticks
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output key_code_t           key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic                key_release
);

  localparam logic [1:0] ST_SCAN     = SCAN;
  localparam logic [1:0] ST_PRESS_DB = PRESS_DB;
  localparam logic [1:0] ST_HELD     = HELD;
  localparam logic [1:0] ST_REL_DB   = REL_DB;

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic                tick;
  logic [NUM_ROWS-1:0] sync1_q;
  logic [NUM_ROWS-1:0] rs_q;

  logic [1:0]    state_q,   state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  key_code_t     code_q,    code_d;
  logic          valid_q,   valid_d;
  logic          down_q,    down_d;
  logic          rel_q,     rel_d;

  logic [NUM_ROWS-1:0] latched_pat;

  scan_tick #(
    .DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Rows are asynchronous keypad lines; two flops before the FSM sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= row;
      rs_q    <= sync1_q;
    end
  end

  assign latched_pat = ~(4'b0001 << row_idx_q);
  assign col         = ~(4'b0001 << col_idx_q);

  // Scan/debounce next-state logic; only tick cycles move the FSM, pulses
  // self-clear on every other cycle.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    down_d    = down_q;
    rel_d     = 1'b0;

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (one_low(rs_q)) begin
            row_idx_d = low_index(rs_q);
            cnt_d     = '0;
            state_d   = ST_PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        ST_PRESS_DB: begin
          if (rs_q == latched_pat) begin
            if (cnt_q == CNT_LAST) begin
              code_d  = {row_idx_q, col_idx_q};
              valid_d = 1'b1;
              down_d  = 1'b1;
              state_d = ST_HELD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end

        ST_HELD: begin
          if (rs_q[row_idx_q]) begin
            cnt_d   = '0;
            state_d = ST_REL_DB;
          end
        end

        ST_REL_DB: begin
          if (!rs_q[row_idx_q]) begin
            state_d = ST_HELD;
          end else if (cnt_q == CNT_LAST) begin
            down_d  = 1'b0;
            rel_d   = 1'b1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      cnt_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
      rel_q     <= rel_d;
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_down    = down_q;
  assign key_release = rel_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan with a behavioural 4x4 keypad and an event scoreboard.
module tb_key_scan;
  import key_scan_pkg::*;

  localparam int DIV = 4;
  localparam int DB  = 3;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic [3:0] row, col;
  key_code_t key_code;
  logic      key_valid, key_down, key_release;

  logic [3:0] pressed [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        is_rel;
    logic [3:0] code;
  } ev_t;
  ev_t sb[$];
  ev_t mon_e;

  key_scan #(
    .SCAN_DIV       (DIV),
    .DEBOUNCE_TICKS (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Keypad: a row line is pulled low when a pressed key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every DUT pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (key_valid || key_release)) begin
      check_val("pulse_excl", 8'(key_valid & key_release), 8'd0);
      if (sb.size() == 0) begin
        check_val("unexpected_evt", 8'({key_valid, key_release}), 8'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("evt_kind", 8'({key_valid, key_release}), mon_e.is_rel ? 8'd1 : 8'd2);
        check_val("evt_down", 8'(key_down), mon_e.is_rel ? 8'd0 : 8'd1);
        if (!mon_e.is_rel) check_val("evt_code", 8'(key_code), 8'(mon_e.code));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    logic [3:0] seen;
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_col", 8'(col), 8'hE);
    check_val("rst_code", 8'(key_code), 8'h0);
    check_val("rst_flags", 8'({key_valid, key_down, key_release}), 8'h0);

    // Idle column walk: each column held DIV clocks
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ec = ~(4'b0001 << ((k / DIV) % 4));
      check_val("idle_col", 8'(col), 8'(ec));
      check_val("idle_out", 8'({key_valid, key_down, key_release, key_code}), 8'h0);
      @(negedge clk);
    end

    // Press row 2 / col 1
    sb.push_back('{1'b0, 4'b1001});
    pressed[2][1] = 1'b1;
    for (int i = 0; i < 100 && !key_down; i++) @(negedge clk);
    check_val("press_down", 8'(key_down), 8'd1);
    check_val("press_code", 8'(key_code), 8'h9);
    check_val("press_col", 8'(col), 8'hD);
    repeat (12) @(negedge clk);
    check_val("held_col", 8'(col), 8'hD);

    // One-tick release glitch must not drop key_down
    pressed[2][1] = 1'b0;
    repeat (DIV) @(negedge clk);
    pressed[2][1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_val("glitch_down", 8'(key_down), 8'd1);
      @(negedge clk);
    end

    // Stable release
    sb.push_back('{1'b1, 4'b0000});
    pressed[2][1] = 1'b0;
    for (int i = 0; i < 100 && !key_release; i++) @(negedge clk);
    check_val("rel_seen", 8'(key_release), 8'd1);
    check_val("rel_down", 8'(key_down), 8'd0);
    repeat (DIV - 1) @(negedge clk);
    check_val("rel_col_hold", 8'(col), 8'hD);
    @(negedge clk);
    check_val("rel_col_adv", 8'(col), 8'hB);

    // Bounce: row 2 low for two ticks only
    for (int i = 0; i < 40 && col != 4'hD; i++) @(negedge clk);
    check_val("bounce_col", 8'(col), 8'hD);
    pressed[2][1] = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    pressed[2][1] = 1'b0;
    for (int i = 0; i < 40 && col != 4'hB; i++) @(negedge clk);
    check_val("bounce_resume", 8'(col), 8'hB);
    check_val("bounce_down", 8'(key_down), 8'd0);

    // Ghosting: rows 0 and 3 together on col 0
    pressed[0][0] = 1'b1;
    pressed[3][0] = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 48; i++) begin
      seen = seen | ~col;
      @(negedge clk);
    end
    check_val("ghost_cols", 8'(seen), 8'hF);
    check_val("ghost_down", 8'(key_down), 8'd0);
    pressed[0][0] = 1'b0;
    pressed[3][0] = 1'b0;

    // Reset while held
    sb.push_back('{1'b0, 4'b1001});
    pressed[2][1] = 1'b1;
    for (int i = 0; i < 100 && !key_down; i++) @(negedge clk);
    check_val("press2_down", 8'(key_down), 8'd1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mrst_col", 8'(col), 8'hE);
    check_val("mrst_code", 8'(key_code), 8'h0);
    check_val("mrst_flags", 8'({key_valid, key_down, key_release}), 8'h0);
    pressed[2][1] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_val("sb_empty", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
